// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the Hamming decode controller.
// Positions are 1-based; parity bits sit at powers of two.
package hamming_pkg;

    localparam int N_DEF  = 7;
    localparam int R_DEF  = 4;
    localparam int CW     = N_DEF + R_DEF;
    localparam int MAX_CW = 64;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    function automatic logic is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Position p participates in syndrome bit i when bit i of p is set.
    function automatic logic covers(input int p, input int i);
        return p[i];
    endfunction

    // Codeword position holding the k-th data bit (k = 1..N).
    function automatic int data_pos(input int k);
        int pos;
        int n;
        pos = 0;
        n   = 0;
        for (int q = 1; q <= MAX_CW; q++) begin
            if (!is_pow2(q) && pos == 0) begin
                n = n + 1;
                if (n == k) pos = q;
            end
        end
        return pos;
    endfunction

    function automatic logic [R_DEF-1:0] syndrome(input logic [1:CW] code);
        logic [R_DEF-1:0] s;
        s = '0;
        for (int p = 1; p <= CW; p++)
            for (int i = 0; i < R_DEF; i++)
                if (covers(p, i)) s[i] = s[i] ^ code[p];
        return s;
    endfunction

    function automatic logic [1:N_DEF] extract_data(input logic [1:CW] code);
        logic [1:N_DEF] d;
        for (int k = 1; k <= N_DEF; k++) d[k] = code[data_pos(k)];
        return d;
    endfunction

endpackage

// File: rtl/hamming_decode_ctrl_syndrome_corr.sv
// Combinational syndrome, single-bit correction and data extraction.
module hamming_syndrome_corr
    import hamming_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int R = R_DEF
) (
    input  logic [1:N+R] code,
    output logic [1:N]   data,
    output logic [R-1:0] syn,
    output logic         corr,
    output logic         perr,
    output logic         uncorr
);

    localparam int W = N + R;

    logic [R-1:0] syn_v;
    int           s;

    always_comb begin
        syn_v = '0;
        for (int p = 1; p <= W; p++)
            for (int i = 0; i < R; i++)
                if (covers(p, i)) syn_v[i] = syn_v[i] ^ code[p];
        s      = int'(syn_v);
        corr   = (s >= 1) && (s <= W) && !is_pow2(s);
        perr   = (s <= W) && is_pow2(s);
        uncorr = (s > W);
        syn    = syn_v;
    end

    // Flipping before extraction only matters on data positions, so fold it per bit.
    for (genvar gi = 1; gi <= N; gi++) begin : g_data
        localparam int P = data_pos(gi);
        assign data[gi] = code[P] ^ (corr && (syn_v == R'(P)));
    end

endmodule

// File: rtl/hamming_decode_ctrl.sv
// Decode controller: input capture, one-cycle decode, held output slot and
// saturating error statistics.
module hamming_decode_ctrl
    import hamming_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int R     = R_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:N+R]     in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:N]       out_data,
    output logic [R-1:0]     out_syn,
    output logic             out_corr,
    output logic             out_perr,
    output logic             out_uncorr,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] cnt_words,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_perr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    state_t           state_q, state_d;
    logic [1:N+R]     code_q, code_d;
    logic             out_valid_q, out_valid_d;
    logic [1:N]       data_q, data_d;
    logic [R-1:0]     syn_q, syn_d;
    logic             corr_q, corr_d, perr_q, perr_d, uncorr_q, uncorr_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       cnt_hit;

    logic [1:N]       dec_data;
    logic [R-1:0]     dec_syn;
    logic             dec_corr, dec_perr, dec_uncorr;

    hamming_syndrome_corr #(.N(N), .R(R)) u_dec (
        .code   (code_q),
        .data   (dec_data),
        .syn    (dec_syn),
        .corr   (dec_corr),
        .perr   (dec_perr),
        .uncorr (dec_uncorr)
    );

    // The slot frees in the same cycle the consumer takes it, allowing back-to-back words.
    assign in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);

    // Counter order: words, corrected, parity error, uncorrectable.
    assign cnt_hit = {uncorr_q, perr_q, corr_q, 1'b1};

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        syn_d       = syn_q;
        corr_d      = corr_q;
        perr_d      = perr_q;
        uncorr_d    = uncorr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    code_d  = in_code;
                    state_d = CALC;
                end
            end
            CALC: begin
                data_d      = dec_data;
                syn_d       = dec_syn;
                corr_d      = dec_corr;
                perr_d      = dec_perr;
                uncorr_d    = dec_uncorr;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        code_d  = in_code;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (out_valid_q && out_ready && cnt_hit[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
            if (stat_clr) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            syn_q       <= '0;
            corr_q      <= 1'b0;
            perr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            syn_q       <= syn_d;
            corr_q      <= corr_d;
            perr_q      <= perr_d;
            uncorr_q    <= uncorr_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign out_syn    = syn_q;
    assign out_corr   = corr_q;
    assign out_perr   = perr_q;
    assign out_uncorr = uncorr_q;
    assign cnt_words  = cnt_q[0];
    assign cnt_corr   = cnt_q[1];
    assign cnt_perr   = cnt_q[2];
    assign cnt_uncorr = cnt_q[3];

endmodule

// File: tb/tb_hamming_decode_ctrl.sv
// Scoreboard bench for hamming_decode_ctrl (N=7, R=4, 2-bit counters so saturation is reachable).
module tb_hamming_decode_ctrl;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:7] data;
        logic [3:0] syn;
        logic       corr;
        logic       perr;
        logic       uncorr;
        int         acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, out_valid, out_ready, stat_clr;
    logic [1:11]      in_code;
    logic [1:7]       out_data;
    logic [3:0]       out_syn;
    logic             out_corr, out_perr, out_uncorr;
    logic [CNT_W-1:0] cnt_words, cnt_corr, cnt_perr, cnt_uncorr;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    // Hand-encoded vectors: data 1011001 -> clean codeword, then single/double flips.
    localparam logic [1:11] CLEAN = 11'b10100111001;
    localparam logic [1:11] F3    = 11'b10000111001;
    localparam logic [1:11] F5    = 11'b10101111001;
    localparam logic [1:11] F6    = 11'b10100011001;
    localparam logic [1:11] F7    = 11'b10100101001;
    localparam logic [1:11] F8    = 11'b10100110001;
    localparam logic [1:11] F11   = 11'b10100111000;
    localparam logic [1:11] F5_9  = 11'b10101111101;
    localparam logic [1:7]  D     = 7'b1011001;
    localparam logic [1:7]  D5_9  = 7'b1111101;

    hamming_decode_ctrl #(.N(7), .R(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_syn    (out_syn),
        .out_corr   (out_corr),
        .out_perr   (out_perr),
        .out_uncorr (out_uncorr),
        .stat_clr   (stat_clr),
        .cnt_words  (cnt_words),
        .cnt_corr   (cnt_corr),
        .cnt_perr   (cnt_perr),
        .cnt_uncorr (cnt_uncorr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:7] d, input logic [3:0] s,
                            input logic co, input logic pe, input logic un);
        exp_t e;
        e.data = d; e.syn = s; e.corr = co; e.perr = pe; e.uncorr = un; e.acc = cyc;
        sb_q.push_back(e);
        $display("accept code=%b exp data=%b syn=%0d c/p/u=%b%b%b cycle=%0d",
                 in_code, d, s, co, pe, un, cyc);
    endtask

    // Present a word and wait (bounded) for the accepting edge.
    task automatic send(input logic [1:11] c, input logic [1:7] d, input logic [3:0] s,
                        input logic co, input logic pe, input logic un);
        bit done = 0;
        in_code  = c;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(d, s, co, pe, un);
                done = 1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: scoreboard pops, latency, stability, handshake rule and counter model.
    int         m_words = 0, m_corr = 0, m_perr = 0, m_uncorr = 0;
    bit         ov_prev = 0, hs_prev = 0;
    logic [1:7] s_data;
    logic [3:0] s_syn;
    logic [2:0] s_flags;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_words = 0; m_corr = 0; m_perr = 0; m_uncorr = 0;
            ov_prev = 0; hs_prev = 0;
        end else begin
            check("cnt_words", cnt_words, m_words);
            check("cnt_corr", cnt_corr, m_corr);
            check("cnt_perr", cnt_perr, m_perr);
            check("cnt_uncorr", cnt_uncorr, m_uncorr);
            if (out_valid) check("in_ready_in_out", in_ready, out_ready);
            if (out_valid && !ov_prev) begin
                if (sb_q.size() == 0) check("unexpected_out_valid", 1, 0);
                else check("latency", cyc - sb_q[0].acc, 2);
            end
            if (out_valid && ov_prev && !hs_prev) begin
                check("hold_data", out_data, s_data);
                check("hold_syn", out_syn, s_syn);
                check("hold_flags", {out_corr, out_perr, out_uncorr}, s_flags);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_empty", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("deliver data=%b syn=%0d c/p/u=%b%b%b cycle=%0d",
                             out_data, out_syn, out_corr, out_perr, out_uncorr, cyc);
                    check("out_data", out_data, e.data);
                    check("out_syn", out_syn, e.syn);
                    check("out_corr", out_corr, e.corr);
                    check("out_perr", out_perr, e.perr);
                    check("out_uncorr", out_uncorr, e.uncorr);
                    m_words  = sat(m_words);
                    if (e.corr)   m_corr   = sat(m_corr);
                    if (e.perr)   m_perr   = sat(m_perr);
                    if (e.uncorr) m_uncorr = sat(m_uncorr);
                end
            end
            if (stat_clr) begin
                m_words = 0; m_corr = 0; m_perr = 0; m_uncorr = 0;
            end
            s_data  = out_data;
            s_syn   = out_syn;
            s_flags = {out_corr, out_perr, out_uncorr};
            ov_prev = out_valid;
            hs_prev = out_valid && out_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_out_valid();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; stat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);
        check("reset_out_syn", out_syn, 0);
        check("reset_flags", {out_corr, out_perr, out_uncorr}, 0);
        @(posedge clk); #1;

        // Clean, single data flip, parity flip, double flip.
        send(CLEAN, D, 4'd0, 0, 0, 0);
        send(F6, D, 4'd6, 1, 0, 0);
        send(F8, D, 4'd8, 0, 1, 0);
        send(F5_9, D5_9, 4'd12, 0, 0, 1);
        repeat (4) @(posedge clk);
        #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;

        // Stall the consumer with a second word waiting, then release for back-to-back.
        out_ready = 1'b0;
        send(CLEAN, D, 4'd0, 0, 0, 0);
        in_code  = F6;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("b2b_accept", in_ready && out_valid, 1);
        push_exp(D, 4'd6, 1, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Five corrected words saturate the 2-bit counters.
        send(F3, D, 4'd3, 1, 0, 0);
        send(F5, D, 4'd5, 1, 0, 0);
        send(F7, D, 4'd7, 1, 0, 0);
        send(F11, D, 4'd11, 1, 0, 0);
        send(F6, D, 4'd6, 1, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sat_cnt_corr", cnt_corr, CNT_MAX);
        @(posedge clk); #1;

        // Clear coinciding with a delivery handshake.
        out_ready = 1'b0;
        send(F3, D, 4'd3, 1, 0, 0);
        wait_out_valid();
        @(posedge clk); #1 stat_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        check("clr_wins_corr", cnt_corr, 0);
        @(posedge clk); #1;

        // Reset while the word is in CALC.
        send(CLEAN, D, 4'd0, 0, 0, 0);
        send(F6, D, 4'd6, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_calc_out_valid", out_valid, 0);
        end
        check("rst_calc_cnt_words", cnt_words, 0);
        check("rst_calc_cnt_corr", cnt_corr, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
